// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding and timing defaults for the traffic controller
package traffic_pkg;

    localparam int CNT_W   = 7;
    localparam int MAX_DUR = 99;
    localparam int RED_DEF = 2;
    localparam int YEL_DEF = 3;
    localparam int GRN_DEF = 10;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_R    = 2'd1,
        PH_Y    = 2'd2,
        PH_G    = 2'd3
    } phase_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to a one-cycle tick every TICK_DIV cycles
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : restart the count from zero (wins over en)
//   en    : advance the count; when low the count is held and no tick is raised
//   tick  : high while the count sits at TICK_DIV-1 and en is high
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] cnt;
    logic          at_top;

    assign at_top = (cnt == PW'(TICK_DIV - 1));
    assign tick   = en && at_top;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_top ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - programmable phase durations, 1 s countdown and phase-expiry strobes
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   fsm_r/fsm_y/fsm_g   : sequencer phase indicators (priority r > y > g)
//   set_mode            : programming mode; freezes timing and suppresses strobes
//   sel_phase           : duration to edit (0 red, 1 yellow, 2 green, 3 none)
//   inc                 : increment the selected duration (set_mode only)
//   r_end/y_end/g_end   : one-cycle expiry strobes back to the sequencer
//   remain              : remaining seconds, or the selected duration in set_mode
module phase_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = traffic_pkg::CNT_W,
    parameter int MAX_DUR  = traffic_pkg::MAX_DUR,
    parameter int RED_DEF  = traffic_pkg::RED_DEF,
    parameter int YEL_DEF  = traffic_pkg::YEL_DEF,
    parameter int GRN_DEF  = traffic_pkg::GRN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fsm_r,
    input  logic             fsm_y,
    input  logic             fsm_g,
    input  logic             set_mode,
    input  logic [1:0]       sel_phase,
    input  logic             inc,
    output logic             r_end,
    output logic             y_end,
    output logic             g_end,
    output logic [CNT_W-1:0] remain
);

    import traffic_pkg::*;

    // Durations never hold zero: the wrap goes MAX_DUR -> 1.
    function automatic logic [CNT_W-1:0] dur_bump(input logic [CNT_W-1:0] d);
        return (d >= CNT_W'(MAX_DUR)) ? CNT_W'(1) : d + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] dur_r, dur_y, dur_g;
    logic [CNT_W-1:0] dur_r_nxt, dur_y_nxt, dur_g_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] act_dur, sel_dur_nxt;
    phase_t           active, prev_phase;
    logic             set_mode_d;
    logic             run, load, tick, expire;

    always_comb begin
        active = PH_NONE;
        if (fsm_r)      active = PH_R;
        else if (fsm_y) active = PH_Y;
        else if (fsm_g) active = PH_G;
    end

    always_comb begin
        act_dur = '0;
        case (active)
            PH_R:    act_dur = dur_r;
            PH_Y:    act_dur = dur_y;
            PH_G:    act_dur = dur_g;
            default: act_dur = '0;
        endcase
    end

    // Leaving set_mode forces a reload even if the phase looks unchanged,
    // because the durations may have been edited underneath it.
    assign run    = !set_mode && (active != PH_NONE);
    assign load   = run && ((active != prev_phase) || set_mode_d);
    assign expire = run && !load && tick && (cnt == CNT_W'(1));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (set_mode || load),
        .en    (run),
        .tick  (tick)
    );

    always_comb begin
        dur_r_nxt = dur_r;
        dur_y_nxt = dur_y;
        dur_g_nxt = dur_g;
        if (set_mode && inc) begin
            case (sel_phase)
                2'd0:    dur_r_nxt = dur_bump(dur_r);
                2'd1:    dur_y_nxt = dur_bump(dur_y);
                2'd2:    dur_g_nxt = dur_bump(dur_g);
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_dur_nxt = '0;
        case (sel_phase)
            2'd0:    sel_dur_nxt = dur_r_nxt;
            2'd1:    sel_dur_nxt = dur_y_nxt;
            2'd2:    sel_dur_nxt = dur_g_nxt;
            default: sel_dur_nxt = '0;
        endcase
    end

    // Expiry reloads the same duration so a stalled sequencer gets repeated strobes.
    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = act_dur;
        end else if (run && tick) begin
            if (cnt == CNT_W'(1))     cnt_nxt = act_dur;
            else if (cnt > CNT_W'(1)) cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_r      <= CNT_W'(RED_DEF);
            dur_y      <= CNT_W'(YEL_DEF);
            dur_g      <= CNT_W'(GRN_DEF);
            cnt        <= '0;
            prev_phase <= PH_NONE;
            set_mode_d <= 1'b0;
            r_end      <= 1'b0;
            y_end      <= 1'b0;
            g_end      <= 1'b0;
            remain     <= '0;
        end else begin
            dur_r      <= dur_r_nxt;
            dur_y      <= dur_y_nxt;
            dur_g      <= dur_g_nxt;
            cnt        <= cnt_nxt;
            set_mode_d <= set_mode;
            if (load) prev_phase <= active;
            r_end      <= expire && (active == PH_R);
            y_end      <= expire && (active == PH_Y);
            g_end      <= expire && (active == PH_G);
            remain     <= set_mode ? sel_dur_nxt : cnt_nxt;
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - directed table-driven bench for phase_timer
module tb_phase_timer;

    localparam int TD = 4;

    typedef struct {
        logic       r, y, g, sm;
        logic [1:0] sel;
        logic       inc;
        logic       er, ey, eg;
        logic [6:0] rem;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fsm_r, fsm_y, fsm_g, set_mode, inc;
    logic [1:0] sel_phase;
    logic       r_end, y_end, g_end;
    logic [6:0] remain;

    int pass_cnt = 0;
    int total    = 0;

    vec_t tbl[$];

    phase_timer #(
        .TICK_DIV (TD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fsm_r     (fsm_r),
        .fsm_y     (fsm_y),
        .fsm_g     (fsm_g),
        .set_mode  (set_mode),
        .sel_phase (sel_phase),
        .inc       (inc),
        .r_end     (r_end),
        .y_end     (y_end),
        .g_end     (g_end),
        .remain    (remain)
    );

    always #5 clk = ~clk;

    // Vector j of a phase of n seconds entered at j = 0 (the load edge).
    function automatic vec_t make_vec(input int ph, input int n, input int j);
        vec_t v;
        int   per;
        logic fin;
        per   = n * TD;
        fin   = (j > 0) && (j % per == 0);
        v.r   = (ph == 0);
        v.y   = (ph == 1);
        v.g   = (ph == 2);
        v.sm  = 1'b0;
        v.sel = 2'd0;
        v.inc = (j % 7 == 3);
        v.er  = (ph == 0) && fin;
        v.ey  = (ph == 1) && fin;
        v.eg  = (ph == 2) && fin;
        v.rem = 7'(n - (j % per) / TD);
        return v;
    endfunction

    function automatic vec_t mk_edit(input logic [1:0] sel, input logic i, input int rem);
        vec_t v;
        v.r = 1'b1; v.y = 1'b0; v.g = 1'b0; v.sm = 1'b1;
        v.sel = sel; v.inc = i;
        v.er = 1'b0; v.ey = 1'b0; v.eg = 1'b0;
        v.rem = 7'(rem);
        return v;
    endfunction

    task automatic add_phase(input int ph, input int n, input int nvec);
        for (int j = 0; j < nvec; j++) tbl.push_back(make_vec(ph, n, j));
    endtask

    task automatic check_out(input string name, input logic er, input logic ey,
                             input logic eg, input logic [6:0] rem);
        total++;
        if (r_end === er && y_end === ey && g_end === eg && remain === rem) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s @%0t: got ends(r,y,g)=%b%b%b remain=%0d, want %b%b%b remain=%0d",
                     name, $time, r_end, y_end, g_end, remain, er, ey, eg, rem);
        end
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        fsm_r     = v.r;
        fsm_y     = v.y;
        fsm_g     = v.g;
        set_mode  = v.sm;
        sel_phase = v.sel;
        inc       = v.inc;
        @(posedge clk);
        #1;
        check_out(name, v.er, v.ey, v.eg, v.rem);
    endtask

    task automatic run_phase(input string name, input int ph, input int n, input int nvec);
        for (int j = 0; j < nvec; j++) apply_vec(name, make_vec(ph, n, j));
    endtask

    task automatic async_reset(input string name);
        #3;
        rst_n = 1'b0;
        #1;
        check_out(name, 1'b0, 1'b0, 1'b0, 7'd0);
        @(posedge clk);
        #1;
        check_out(name, 1'b0, 1'b0, 1'b0, 7'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int d;
        vec_t idle;

        rst_n = 1'b0;
        fsm_r = 1'b0; fsm_y = 1'b0; fsm_g = 1'b0;
        set_mode = 1'b0; sel_phase = 2'd0; inc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 1'b0, 1'b0, 7'd0);
        rst_n = 1'b1;

        idle = make_vec(3, 1, 0);
        idle.rem = 7'd0;
        apply_vec("idle_none", idle);
        apply_vec("idle_none", idle);

        // Sequencer r -> y -> g, then y stalls for two repeats and is left
        // for red on the exact cycle of its third expiry tick.
        add_phase(0, 2, 9);
        add_phase(1, 3, 13);
        add_phase(2, 10, 41);
        add_phase(1, 3, 36);
        add_phase(0, 2, 9);
        foreach (tbl[i]) apply_vec("table", tbl[i]);

        // Edit green through the wrap point.
        apply_vec("edit_enter", mk_edit(2'd2, 1'b0, 10));
        d = 10;
        for (int p = 1; p <= 90; p++) begin
            d = (d == 99) ? 1 : d + 1;
            apply_vec((p == 89) ? "edit_g_99" : (p == 90) ? "edit_g_wrap" : "edit_g",
                      mk_edit(2'd2, 1'b1, d));
            apply_vec("edit_g_hold", mk_edit(2'd2, 1'b0, d));
        end
        apply_vec("edit_sel3", mk_edit(2'd3, 1'b1, 0));
        apply_vec("edit_sel3_g", mk_edit(2'd2, 1'b0, 1));

        run_phase("exit_red", 0, 2, 9);
        run_phase("green_dur1", 2, 1, 9);

        // Edit lost by a reset in the middle of editing.
        apply_vec("edit_r", mk_edit(2'd0, 1'b0, 2));
        apply_vec("edit_r", mk_edit(2'd0, 1'b1, 3));
        apply_vec("edit_r", mk_edit(2'd0, 1'b1, 4));
        apply_vec("edit_r", mk_edit(2'd0, 1'b1, 5));
        async_reset("reset_mid_edit");

        run_phase("green_after_rst", 2, 10, 22);
        async_reset("reset_mid_count");
        run_phase("green_reload", 2, 10, 41);
        run_phase("yel_default", 1, 3, 1);
        run_phase("red_default", 0, 2, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
